// File: rtl/ifetch_unit_pkg.sv
// Shared MIPS fetch definitions: reset defaults, fetch state encoding and
// instruction field positions.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int JIDX_HI  = 25;
  localparam int JIDX_LO  = 0;

endpackage

// File: rtl/ifetch_unit_pc_next.sv
// Next-PC selection: sequential, PC-relative branch or pseudo-direct jump.
module pc_next
  import mips_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] signimm,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pcplus4,
  output logic [31:0] next_pc
);

  logic [31:0] pcbranch;
  logic [31:0] pcjump;
  logic        unused_bits;

  assign pcplus4  = pc + 32'd4;
  // Word offset: the top two immediate bits fall off the shift.
  assign pcbranch = pcplus4 + {signimm[29:0], 2'b00};
  assign pcjump   = {pcplus4[31:28], instr[JIDX_HI:JIDX_LO], 2'b00};

  assign unused_bits = ^{instr[31:26], signimm[31:30]};

  always_comb begin
    next_pc = pcplus4;
    if (jump)       next_pc = pcjump;
    else if (pcsrc) next_pc = pcbranch;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from imem and holds the
// fetched word in the instruction register until the controller releases it.
module ifetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  fetch_state_t state;
  logic [31:0]  next_pc;

  pc_next u_pc_next (
    .pc      (pc),
    .instr   (instr),
    .signimm (signimm),
    .pcsrc   (pcsrc),
    .jump    (jump),
    .pcplus4 (pcplus4),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_rvalid) begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: if (!stall) begin
          pc          <= next_pc;
          instr       <= NOP_WORD;
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Request is a level on state so a zero-wait response lands in the same cycle.
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;
  assign op        = instr[OP_HI:OP_LO];
  assign funct     = instr[FUNCT_HI:FUNCT_LO];

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a driver plays memory and controller, a
// monitor checks fetch addresses, timing and the instruction register.
module tb_ifetch_unit;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcsrc = 1'b0, jump = 1'b0, stall = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] signimm = '0, imem_rdata = '0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pcplus4;
  logic [5:0]  op, funct;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  int          exp_gap_q[$];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .signimm     (signimm),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .op          (op),
    .funct       (funct),
    .pc          (pc),
    .pcplus4     (pcplus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a new request or instruction.
  initial begin : monitor
    logic        prev_req, prev_v, have_last;
    int          cyc, last;
    logic [31:0] cur_addr, held;
    prev_req = 0; prev_v = 0; have_last = 0; cyc = 0; last = 0; cur_addr = '0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("req_in_reset", 32'(imem_req), 32'd0);
        chk("pc_in_reset", pc, RESET_PC_DEF);
        chk("valid_in_reset", 32'(instr_valid), 32'd0);
        prev_req = 0; prev_v = 0; have_last = 0;
      end else begin
        if (imem_req && !prev_req) begin
          if (exp_addr_q.size() == 0) chk("unexpected_req", 32'(imem_addr), 32'hDEAD_BEEF);
          else begin
            cur_addr = exp_addr_q.pop_front();
            chk("imem_addr", imem_addr, cur_addr);
          end
          if (have_last) begin
            if (exp_gap_q.size() == 0) chk("gap_missing", 32'(cyc - last), 32'hFFFF_FFFF);
            else chk("cycles_per_instr", 32'(cyc - last), 32'(exp_gap_q.pop_front()));
          end
          have_last = 1; last = cyc;
        end else if (imem_req) begin
          chk("addr_stable", imem_addr, cur_addr);
        end
        if (imem_req) chk("pcplus4", pcplus4, cur_addr + 32'd4);
        if (instr_valid && !prev_v) begin
          if (exp_instr_q.size() == 0) chk("unexpected_valid", instr, 32'hDEAD_BEEF);
          else begin
            held = exp_instr_q.pop_front();
            chk("instr", instr, held);
            chk("op", 32'(op), 32'(held >> 26));
            chk("funct", 32'(funct), held & 32'h3F);
          end
        end else if (instr_valid) begin
          chk("instr_hold", instr, held);
        end
        if (instr_valid) begin
          chk("req_low_in_issue", 32'(imem_req), 32'd0);
          chk("pc_hold", pc, cur_addr);
        end else begin
          chk("instr_nop", instr, NOP_WORD_DEF);
          chk("op_nop", 32'(op), 32'd0);
        end
        prev_req = imem_req; prev_v = instr_valid;
      end
    end
  end

  // One instruction: wait for request, answer after lat cycles, stall st cycles,
  // then release with the given controller decision. Entered and left at a negedge.
  task automatic do_instr(input int lat, input int st, input logic [31:0] word,
                          input logic pcs, input logic jmp, input logic [31:0] si,
                          input logic spur);
    int n;
    logic [31:0] p4;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    if (!imem_req) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (lat) begin
      imem_rvalid = 1'b0;
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    stall       = 1'($urandom_range(0, 1));
    exp_instr_q.push_back(word);
    @(negedge clk);
    imem_rvalid = 1'b0;
    repeat (st) begin
      stall       = 1'b1;
      pcsrc       = 1'($urandom_range(0, 1));
      jump        = 1'($urandom_range(0, 1));
      signimm     = $urandom;
      imem_rvalid = spur;
      imem_rdata  = $urandom;
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    stall = 1'b0; pcsrc = pcs; jump = jmp; signimm = si;
    p4 = mpc + 32'd4;
    if (jmp)      mpc = (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    else if (pcs) mpc = p4 + si * 32'd4;
    else          mpc = p4;
    exp_addr_q.push_back(mpc);
    exp_gap_q.push_back(lat + st + 2);
    @(negedge clk);
    pcsrc = 1'b0; jump = 1'b0;
  endtask

  initial begin : driver
    int n;
    logic [31:0] si;
    mpc = RESET_PC_DEF;
    exp_addr_q.push_back(RESET_PC_DEF);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    do_instr(0, 0, 32'h2008_0005, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(2, 0, 32'h0800_0010, 1'b1, 1'b1, 32'h3, 1'b0);

    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    chk("midrst_pc", pc, RESET_PC_DEF);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    exp_addr_q.delete(); exp_instr_q.delete(); exp_gap_q.delete();
    mpc = RESET_PC_DEF;
    exp_addr_q.push_back(RESET_PC_DEF);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    do_instr(2, 0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(2, 0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(2, 0, $urandom, 1'b1, 1'b0, 32'h3, 1'b0);
    do_instr(1, 0, $urandom, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    do_instr(0, 3, $urandom, 1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 40; i++)
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               $urandom, 1'($urandom_range(0, 1)));

    si = (32'hFFFF_FFFC - (mpc + 32'd4)) / 32'd4;
    do_instr(0, 0, $urandom, 1'b1, 1'b0, si, 1'b0);
    do_instr(1, 1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
    do_instr(0, 0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(exp_addr_q.size() + exp_instr_q.size() + exp_gap_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
